// File: rtl/alu_issue_pkg.sv
// Shared definitions for the ALU issue block: ALU opcodes, branch funct3 codes, FSM states, request payload.
package alu_issue_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned AOPW = 4;
    localparam int unsigned F3W  = 3;
    localparam int unsigned LATW = 6;

    localparam logic [AOPW-1:0] ALUOP_ADD  = 4'd0;
    localparam logic [AOPW-1:0] ALUOP_SUB  = 4'd1;
    localparam logic [AOPW-1:0] ALUOP_SLL  = 4'd2;
    localparam logic [AOPW-1:0] ALUOP_SLT  = 4'd3;
    localparam logic [AOPW-1:0] ALUOP_SLTU = 4'd4;
    localparam logic [AOPW-1:0] ALUOP_XOR  = 4'd5;
    localparam logic [AOPW-1:0] ALUOP_SRL  = 4'd6;
    localparam logic [AOPW-1:0] ALUOP_SRA  = 4'd7;
    localparam logic [AOPW-1:0] ALUOP_OR   = 4'd8;
    localparam logic [AOPW-1:0] ALUOP_AND  = 4'd9;

    localparam logic [F3W-1:0] BRF3_BEQ  = 3'b000;
    localparam logic [F3W-1:0] BRF3_BNE  = 3'b001;
    localparam logic [F3W-1:0] BRF3_BLT  = 3'b100;
    localparam logic [F3W-1:0] BRF3_BGE  = 3'b101;
    localparam logic [F3W-1:0] BRF3_BLTU = 3'b110;
    localparam logic [F3W-1:0] BRF3_BGEU = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DONE  = 3'd3,
        ST_FAULT = 3'd4
    } state_t;

    typedef struct packed {
        logic [XLEN-1:0] op1;
        logic [XLEN-1:0] op2;
        logic [AOPW-1:0] aluop;
    } alu_req_t;

endpackage

// File: rtl/alu_issue_brcond.sv
// Branch condition decode: RISC-V branch funct3 plus captured ALU compare flags -> taken.
module alu_issue_brcond
    import alu_issue_pkg::*;
(
    input  logic [F3W-1:0] funct3,
    input  logic           lt,
    input  logic           ltu,
    input  logic           eq,
    output logic           take_c
);

    always_comb begin
        take_c = 1'b0;
        case (funct3)
            BRF3_BEQ:  take_c = eq;
            BRF3_BNE:  take_c = ~eq;
            BRF3_BLT:  take_c = lt;
            BRF3_BGE:  take_c = ~lt;
            BRF3_BLTU: take_c = ltu;
            BRF3_BGEU: take_c = ~ltu;
            default:   take_c = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_issue.sv
// Execute-stage initiator for the ALU en/busy handshake; returns result, latency and branch decision.
// Optional branch decode is enabled by defining ALU_ISSUE_BRANCH_EN.
module alu_issue
    import alu_issue_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 40
) (
    input  logic            I_clk,
    input  logic            I_reset,
    input  logic            I_valid,
    output logic            O_ready,
    input  logic [XLEN-1:0] I_op1,
    input  logic [XLEN-1:0] I_op2,
    input  logic [AOPW-1:0] I_aluop,
    input  logic            I_branch,
    input  logic [F3W-1:0]  I_brfunct3,
    output logic            O_done,
    output logic [XLEN-1:0] O_result,
    output logic            O_take,
    output logic            O_err,
    output logic [LATW-1:0] O_lat,
    output logic            O_alu_en,
    output logic [XLEN-1:0] O_alu_s1,
    output logic [XLEN-1:0] O_alu_s2,
    output logic [AOPW-1:0] O_alu_op,
    input  logic            I_alu_busy,
    input  logic [XLEN-1:0] I_alu_data,
    input  logic            I_alu_lt,
    input  logic            I_alu_ltu,
    input  logic            I_alu_eq
);

    localparam logic [LATW-1:0] WAIT_LIMIT = LATW'(MAX_WAIT);

    state_t          state_q, state_d;
    alu_req_t        req_q, req_d;
    logic [LATW-1:0] cnt_q, cnt_d, cnt_inc;
    logic            ready_q, done_q, take_q, err_q;
    logic [XLEN-1:0] result_q;
    logic [LATW-1:0] lat_q;
    logic            alu_en_c, accept, capture, timeout, take_d;

    // Next state; en follows busy in WAIT so it drops the very cycle the ALU finishes.
    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        cnt_d    = cnt_q;
        alu_en_c = 1'b0;
        accept   = 1'b0;
        capture  = 1'b0;
        timeout  = 1'b0;
        cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + LATW'(1);
        case (state_q)
            ST_IDLE: begin
                if (I_valid) begin
                    accept  = 1'b1;
                    req_d   = '{op1: I_op1, op2: I_op2, aluop: I_aluop};
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                alu_en_c = 1'b1;
                cnt_d    = '0;
                state_d  = ST_WAIT;
            end
            ST_WAIT: begin
                if (I_alu_busy) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == WAIT_LIMIT) begin
                        timeout = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        alu_en_c = 1'b1;
                    end
                end else begin
                    capture = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE:  state_d = err_q ? ST_FAULT : ST_IDLE;
            ST_FAULT: state_d = ST_FAULT;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge I_clk) begin
        if (I_reset) begin
            state_q  <= ST_IDLE;
            req_q    <= '0;
            cnt_q    <= '0;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
            take_q   <= 1'b0;
            err_q    <= 1'b0;
            result_q <= '0;
            lat_q    <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            cnt_q   <= cnt_d;
            ready_q <= (state_d == ST_IDLE);
            done_q  <= capture | timeout;
            if (capture | timeout) begin
                result_q <= I_alu_data;
                lat_q    <= cnt_d;
                take_q   <= take_d;
            end
            if (timeout) begin
                err_q <= 1'b1;
            end
        end
    end

`ifdef ALU_ISSUE_BRANCH_EN
    logic           br_q;
    logic [F3W-1:0] f3_q;
    logic           br_take_c;

    always_ff @(posedge I_clk) begin
        if (I_reset) begin
            br_q <= 1'b0;
            f3_q <= '0;
        end else if (accept) begin
            br_q <= I_branch;
            f3_q <= I_brfunct3;
        end
    end

    alu_issue_brcond u_brcond (
        .funct3 (f3_q),
        .lt     (I_alu_lt),
        .ltu    (I_alu_ltu),
        .eq     (I_alu_eq),
        .take_c (br_take_c)
    );

    // Flags are sampled live on the capture edge, alongside the result.
    assign take_d = capture & br_q & br_take_c;
`else
    logic unused_branch;
    assign unused_branch = ^{accept, I_branch, I_brfunct3, I_alu_lt, I_alu_ltu, I_alu_eq};
    assign take_d        = 1'b0;
`endif

    assign O_ready  = ready_q;
    assign O_done   = done_q;
    assign O_result = result_q;
    assign O_take   = take_q;
    assign O_err    = err_q;
    assign O_lat    = lat_q;
    assign O_alu_en = alu_en_c;
    assign O_alu_s1 = req_q.op1;
    assign O_alu_s2 = req_q.op2;
    assign O_alu_op = req_q.aluop;

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: two instances (MAX_WAIT 40 and 4), each with a behavioural multi-cycle ALU.
module tb_alu_issue;
    import alu_issue_pkg::*;

`ifdef ALU_ISSUE_BRANCH_EN
    localparam bit BR_EN = 1'b1;
`else
    localparam bit BR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  valid = 2'b00;
    logic [31:0] op1 = '0, op2 = '0;
    logic [3:0]  aluop = '0;
    logic        branch = 1'b0;
    logic [2:0]  f3 = '0;

    logic [1:0]  ready, done, take, err, en, busy, flt, fltu, feq;
    logic [31:0] result [2];
    logic [31:0] s1 [2];
    logic [31:0] s2 [2];
    logic [31:0] adata [2];
    logic [3:0]  aop [2];
    logic [5:0]  lat [2];
    int          en_cnt [2];
    int          starts [2];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    function automatic logic is_shift(input logic [3:0] op);
        return (op == ALUOP_SLL) || (op == ALUOP_SRL) || (op == ALUOP_SRA);
    endfunction

    function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            ALUOP_ADD:  return a + b;
            ALUOP_SUB:  return a - b;
            ALUOP_SLL:  return a << b[4:0];
            ALUOP_SLT:  return {31'b0, $signed(a) < $signed(b)};
            ALUOP_SLTU: return {31'b0, a < b};
            ALUOP_XOR:  return a ^ b;
            ALUOP_SRL:  return a >> b[4:0];
            ALUOP_SRA:  return $unsigned($signed(a) >>> b[4:0]);
            ALUOP_OR:   return a | b;
            ALUOP_AND:  return a & b;
            default:    return 32'h0;
        endcase
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_lane
        localparam int unsigned MW = (g == 0) ? 40 : 4;

        alu_issue #(.MAX_WAIT(MW)) u_dut (
            .I_clk      (clk),
            .I_reset    (rst),
            .I_valid    (valid[g]),
            .O_ready    (ready[g]),
            .I_op1      (op1),
            .I_op2      (op2),
            .I_aluop    (aluop),
            .I_branch   (branch),
            .I_brfunct3 (f3),
            .O_done     (done[g]),
            .O_result   (result[g]),
            .O_take     (take[g]),
            .O_err      (err[g]),
            .O_lat      (lat[g]),
            .O_alu_en   (en[g]),
            .O_alu_s1   (s1[g]),
            .O_alu_s2   (s2[g]),
            .O_alu_op   (aop[g]),
            .I_alu_busy (busy[g]),
            .I_alu_data (adata[g]),
            .I_alu_lt   (flt[g]),
            .I_alu_ltu  (fltu[g]),
            .I_alu_eq   (feq[g])
        );

        // ALU model: shifts stay busy for shamt+1 cycles; en while idle starts an op.
        logic        m_busy;
        logic [4:0]  m_cnt;
        logic [31:0] m_data, m_shres;
        int          m_en_cnt = 0;
        int          m_starts = 0;

        always @(posedge clk) begin
            if (rst) begin
                m_busy <= 1'b0;
                m_cnt  <= '0;
                m_data <= '0;
                m_shres <= '0;
            end else if (m_busy) begin
                if (m_cnt == 5'd0) begin
                    m_busy <= 1'b0;
                    m_data <= m_shres;
                end else begin
                    m_cnt <= m_cnt - 5'd1;
                end
            end else if (en[g]) begin
                m_starts <= m_starts + 1;
                if (is_shift(aop[g])) begin
                    m_busy  <= 1'b1;
                    m_cnt   <= s2[g][4:0];
                    m_shres <= alu_fn(aop[g], s1[g], s2[g]);
                end else begin
                    m_data <= alu_fn(aop[g], s1[g], s2[g]);
                end
            end
            if (!rst && en[g]) m_en_cnt <= m_en_cnt + 1;
        end

        assign busy[g]   = m_busy;
        assign adata[g]  = m_data;
        assign flt[g]    = $signed(s1[g]) < $signed(s2[g]);
        assign fltu[g]   = s1[g] < s2[g];
        assign feq[g]    = s1[g] == s2[g];
        assign en_cnt[g] = m_en_cnt;
        assign starts[g] = m_starts;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
        end
    endtask

    // Issue one op on a lane, track it to O_done, check timing, payload and held outputs.
    task automatic run_op(input int lane, input int id, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] op, input logic br, input logic [2:0] fn,
                          input int exp_cyc, input logic [31:0] exp_res, input bit chk_res,
                          input logic [5:0] exp_lat, input logic exp_take, input logic exp_err,
                          input int exp_en);
        int cyc;
        int en0;
        int st0;
        int hold_bad;
        bit got;
        cyc = 0;
        while (!ready[lane] && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk($sformatf("v%0d_ready_wait", id), 32'(ready[lane]), 32'd1);
        @(negedge clk);
        op1 = a; op2 = b; aluop = op; branch = br; f3 = fn;
        valid[lane] = 1'b1;
        en0 = en_cnt[lane];
        st0 = starts[lane];
        @(posedge clk); #1;
        valid[lane] = 1'b0;
        op1 = $urandom; op2 = $urandom; aluop = 4'($urandom);
        branch = 1'($urandom); f3 = 3'($urandom);
        cyc = 1;
        got = 1'b0;
        hold_bad = 0;
        for (int k = 0; k < exp_cyc + 10; k++) begin
            if (done[lane]) begin
                got = 1'b1;
                break;
            end
            if (ready[lane] !== 1'b0 || s1[lane] !== a || s2[lane] !== b || aop[lane] !== op)
                hold_bad++;
            @(posedge clk); #1;
            cyc++;
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL v%0d_done_timeout actual=no_done_after_%0d required=done_at_%0d", id, cyc, exp_cyc);
        end else begin
            chk($sformatf("v%0d_hold", id), 32'(hold_bad), 32'd0);
            chk($sformatf("v%0d_done_cycle", id), 32'(cyc), 32'(exp_cyc));
            if (chk_res) chk($sformatf("v%0d_result", id), result[lane], exp_res);
            chk($sformatf("v%0d_lat", id), 32'(lat[lane]), 32'(exp_lat));
            chk($sformatf("v%0d_take", id), 32'(take[lane]), 32'(exp_take));
            chk($sformatf("v%0d_err", id), 32'(err[lane]), 32'(exp_err));
            chk($sformatf("v%0d_ready_at_done", id), 32'(ready[lane]), 32'd0);
            @(posedge clk); #1;
            chk($sformatf("v%0d_done_pulse", id), 32'(done[lane]), 32'd0);
            if (chk_res) chk($sformatf("v%0d_result_held", id), result[lane], exp_res);
            chk($sformatf("v%0d_take_held", id), 32'(take[lane]), 32'(exp_take));
            chk($sformatf("v%0d_en_cycles", id), 32'(en_cnt[lane] - en0), 32'(exp_en));
            chk($sformatf("v%0d_alu_starts", id), 32'(starts[lane] - st0), 32'd1);
        end
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic        br;
        logic [2:0]  f3;
        int          cyc;
        logic [31:0] res;
        logic [5:0]  lat;
        logic        take;
    } vec_t;

    vec_t tbl [13];

    initial begin : main
        int en0;
        int dcount;
        tbl[0]  = '{32'd5,        32'd7,        ALUOP_ADD, 1'b0, 3'b000, 3,  32'd12,        6'd0,  1'b0};
        tbl[1]  = '{32'd1,        32'd31,       ALUOP_SLL, 1'b0, 3'b000, 35, 32'h8000_0000, 6'd32, 1'b0};
        tbl[2]  = '{32'h8000_0000, 32'd4,       ALUOP_SRA, 1'b0, 3'b000, 8,  32'hF800_0000, 6'd5,  1'b0};
        tbl[3]  = '{32'd1,        32'd1,        ALUOP_ADD, 1'b0, 3'b000, 3,  32'd2,         6'd0,  1'b0};
        tbl[4]  = '{32'hFFFF_FFFF, 32'd1,       ALUOP_SUB, 1'b1, 3'b100, 3,  32'hFFFF_FFFE, 6'd0,  1'b1};
        tbl[5]  = '{32'hFFFF_FFFF, 32'd1,       ALUOP_SUB, 1'b1, 3'b110, 3,  32'hFFFF_FFFE, 6'd0,  1'b0};
        tbl[6]  = '{32'd3,        32'd3,        ALUOP_SUB, 1'b1, 3'b000, 3,  32'd0,         6'd0,  1'b1};
        tbl[7]  = '{32'd3,        32'd3,        ALUOP_SUB, 1'b1, 3'b001, 3,  32'd0,         6'd0,  1'b0};
        tbl[8]  = '{32'd5,        32'd3,        ALUOP_SUB, 1'b1, 3'b111, 3,  32'd2,         6'd0,  1'b1};
        tbl[9]  = '{32'd3,        32'd3,        ALUOP_SUB, 1'b1, 3'b011, 3,  32'd0,         6'd0,  1'b0};
        tbl[10] = '{32'd3,        32'd3,        ALUOP_SUB, 1'b0, 3'b000, 3,  32'd0,         6'd0,  1'b0};
        tbl[11] = '{32'h8000_0000, 32'd0,       ALUOP_SRL, 1'b0, 3'b000, 4,  32'h8000_0000, 6'd1,  1'b0};
        tbl[12] = '{32'hF0F0_F0F0, 32'hFFFF_0000, ALUOP_XOR, 1'b0, 3'b000, 3, 32'h0F0F_F0F0, 6'd0,  1'b0};

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int l = 0; l < 2; l++) begin
            chk($sformatf("rst%0d_ready", l), 32'(ready[l]), 32'd1);
            chk($sformatf("rst%0d_done", l), 32'(done[l]), 32'd0);
            chk($sformatf("rst%0d_take", l), 32'(take[l]), 32'd0);
            chk($sformatf("rst%0d_err", l), 32'(err[l]), 32'd0);
            chk($sformatf("rst%0d_en", l), 32'(en[l]), 32'd0);
            chk($sformatf("rst%0d_result", l), result[l], 32'd0);
            chk($sformatf("rst%0d_lat", l), 32'(lat[l]), 32'd0);
            chk($sformatf("rst%0d_s1", l), s1[l], 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            run_op(0, i, tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].br, tbl[i].f3,
                   tbl[i].cyc, tbl[i].res, 1'b1, tbl[i].lat, BR_EN ? tbl[i].take : 1'b0, 1'b0,
                   is_shift(tbl[i].op) ? int'(tbl[i].b[4:0]) + 2 : 1);
        end

        // Reset while the ALU is mid-shift.
        @(negedge clk);
        op1 = 32'd1; op2 = 32'd20; aluop = ALUOP_SLL; branch = 1'b0; f3 = 3'b000;
        valid[0] = 1'b1;
        @(posedge clk); #1;
        valid[0] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("midrst_en_in_wait", 32'(en[0]), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_ready", 32'(ready[0]), 32'd1);
        chk("midrst_done", 32'(done[0]), 32'd0);
        chk("midrst_en", 32'(en[0]), 32'd0);
        chk("midrst_result", result[0], 32'd0);
        chk("midrst_s1", s1[0], 32'd0);
        @(negedge clk);
        rst = 1'b0;
        dcount = 0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk); #1;
            if (done[0]) dcount++;
        end
        chk("midrst_no_done", 32'(dcount), 32'd0);
        run_op(0, 20, 32'd5, 32'd7, ALUOP_ADD, 1'b0, 3'b000, 3, 32'd12, 1'b1, 6'd0, 1'b0, 1'b0, 1);

        // Watchdog on the MAX_WAIT=4 instance: SLL by 10 outlives the limit.
        run_op(1, 30, 32'd1, 32'd10, ALUOP_SLL, 1'b0, 3'b000, 6, 32'd0, 1'b0, 6'd4, 1'b0, 1'b1, 4);
        @(negedge clk);
        op1 = 32'd2; op2 = 32'd3; aluop = ALUOP_ADD;
        valid[1] = 1'b1;
        en0 = en_cnt[1];
        dcount = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (done[1]) dcount++;
        end
        chk("fault_ready", 32'(ready[1]), 32'd0);
        chk("fault_err", 32'(err[1]), 32'd1);
        chk("fault_no_done", 32'(dcount), 32'd0);
        chk("fault_no_issue", 32'(en_cnt[1] - en0), 32'd0);
        @(negedge clk);
        valid[1] = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("fault_rst_ready", 32'(ready[1]), 32'd1);
        chk("fault_rst_err", 32'(err[1]), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op(1, 31, 32'd2, 32'd3, ALUOP_ADD, 1'b0, 3'b000, 3, 32'd5, 1'b1, 6'd0, 1'b0, 1'b0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=sim_time_exceeded required=finish_before_200us");
        $fatal(1, "watchdog");
    end

endmodule
